fetch_stage_unit: RTL and testbench
===================================

Name: fetch_stage_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the hazard detection unit and the ID stage.
- Owns the PC and issues requests to instruction memory over a req/ack handshake with variable latency.
- Delivers fetched instructions into the IF/ID register.
- Consumes `freeze` (the hazard unit's `hazard_detected`) to stall, and `branch_taken`/`branch_addr` from EXE to redirect and flush.

Parameters:
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction width
- PC_RESET, 0, PC value loaded on reset
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  stall request from hazard detection unit; IF/ID and PC hold
- branch_taken  in  1  redirect from EXE; flush IF/ID
- branch_addr  in  ADDR_W  redirect target
- imem_req  out  1  memory request valid
- imem_addr  out  ADDR_W  request address; stable while imem_req=1 and no ack
- imem_ack  in  1  data valid; may assert in the same cycle as imem_req
- imem_rdata  in  DATA_W  instruction, sampled only when imem_ack=1
- id_pc  out  ADDR_W  IF/ID: address of instruction + 4
- id_instr  out  DATA_W  IF/ID: instruction word
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- stall_count  out  CNT_W  saturating count of cycles with freeze=1

Behaviour:
- Reset (rst=1 at edge) sets:
  - pc=PC_RESET, state=REQ
  - id_pc=0, id_instr=0, id_valid=0
  - skid register cleared, stall_count=0
- Reset mid-transaction abandons any outstanding request. The memory side is reset together with this block.
- States: REQ, HOLD, DISCARD.
  - imem_req=1 in REQ and DISCARD, 0 in HOLD.
  - imem_addr = pc in REQ; in DISCARD it is the latched old address.
- REQ, no ack: keep request; pc, imem_addr unchanged.
- REQ, ack, freeze=0:
  - id_instr<=imem_rdata, id_pc<=pc+4, id_valid<=1
  - pc<=pc+4; stay REQ, so back-to-back fetch is possible (1 instruction/cycle with 0-wait memory).
- REQ, ack, freeze=1: imem_rdata→skid, pc+4→skid_pc; go HOLD; IF/ID unchanged.
- HOLD, freeze=1: all state held.
- HOLD, freeze=0: skid→IF/ID (id_valid<=1), pc<=pc+4, go REQ.
- Any cycle with freeze=1 and no branch: IF/ID register holds its value.
- Any cycle with freeze=0 and no instruction transfer: id_valid<=0. id_instr/id_pc keep their value (don't-care).
- branch_taken=1 has priority over freeze and ack:
  - id_valid<=0, id_instr<=0; pc<=branch_addr.
  - REQ with ack this cycle: data dropped; stay REQ.
  - REQ without ack: latch old address; go DISCARD.
  - HOLD: skid dropped; go REQ.
  - DISCARD: pc<=branch_addr (newest target wins); stay DISCARD.
- DISCARD: keep imem_req=1 at the latched old address until ack. The acked data is discarded; go REQ at pc. Never delivered to IF/ID.
- PC arithmetic is modulo 2^ADDR_W; pc+4 wraps from all-ones region to low addresses with no flag. branch_addr is taken as-is (no alignment check).
- stall_count increments on every cycle freeze=1 (including during reset release cycle+1 onward) and saturates at 2^CNT_W−1. It is cleared only by rst.
- All outputs are registered or decoded from state/registers only, except that imem_addr in REQ equals pc. No combinational path from imem_ack/freeze to imem_req.

Test Plan:
- Reset, 0-wait memory (ack same cycle), freeze=0 for 4 cycles → imem_addr 0,4,8,12; id_pc 4,8,12,16 with id_valid=1 from cycle 2.
- Memory with 3-cycle latency at pc=0x10 → imem_addr=0x10 held for 3 cycles; id_instr=rdata, id_pc=0x14 one cycle after ack; id_valid=0 in between.
- Ack at pc=0x20 with freeze=1 for 2 cycles → imem_req=0, IF/ID unchanged, stall_count=2; on release id_pc=0x24 and next imem_addr=0x24.
- branch_taken=1 (addr=0x100) while request at 0x40 is outstanding → id_valid=0; imem_addr stays 0x40 until ack; that data is not delivered; next imem_addr=0x100; id_pc=0x104 after its ack.
- branch_taken and freeze both high while in HOLD → skid dropped, id_valid=0, next imem_addr=branch_addr.
- pc=0xFFFFFFFC fetch → id_pc=0x00000000; next imem_addr=0. Hold freeze=1 for 70000 cycles with CNT_W=16 → stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/fetch_stage_unit.sv
// ---------------------------------------------------------------------------
// fetch_stage_unit
//
// Instruction-fetch stage with its IF/ID pipeline register. Owns the PC,
// fetches from instruction memory over a variable-latency req/ack handshake
// and presents fetched words to the ID stage. Stalls on freeze from the
// hazard unit and redirects/flushes on branch_taken from EXE.
//
// Handshake: the request is live while imem_req=1. imem_addr does not change
// until a cycle where imem_ack=1, and that cycle completes the transfer.
// imem_ack may be high in the first cycle of a request (zero-wait memory).
// imem_rdata is sampled only in a cycle where imem_ack=1.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   freeze            hazard stall; PC and IF/ID hold
//   branch_taken      redirect to branch_addr; flushes IF/ID
//   branch_addr       redirect target (used unaligned, as given)
//   imem_req/addr     memory request and its address
//   imem_ack/rdata    memory completion and instruction word
//   id_pc             IF/ID: address of the instruction + 4
//   id_instr          IF/ID: instruction word
//   id_valid          IF/ID holds a real instruction (0 = bubble)
//   stall_count       saturating count of cycles with freeze=1
//   dbg_state         current fetch FSM state (0=REQ, 1=HOLD, 2=DISCARD)
// ---------------------------------------------------------------------------
module fetch_stage_unit #(
  parameter int                  ADDR_W   = 32,
  parameter int                  DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   PC_RESET = '0,
  parameter int                  CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  output logic              id_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,  // request outstanding at pc
    S_HOLD    = 2'd1,  // fetched word parked in skid while frozen
    S_DISCARD = 2'd2   // draining a request that a branch made stale
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_old_addr;
  logic [DATA_W-1:0]   r_skid;
  logic [ADDR_W-1:0]   r_skid_pc;
  logic [ADDR_W-1:0]   r_id_pc;
  logic [DATA_W-1:0]   r_id_instr;
  logic                r_id_valid;
  logic [CNT_W-1:0]    r_stall_count;

  logic [ADDR_W-1:0]   w_pc_plus4;

  // Wraps modulo 2^ADDR_W by construction.
  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  // Request is decoded from state only, so ack/freeze never reach imem_req
  // combinationally. A stale request keeps its original address so the
  // memory sees a stable address until it acks.
  assign imem_req    = (r_state != S_HOLD);
  assign imem_addr   = (r_state == S_DISCARD) ? r_old_addr : r_pc;

  assign id_pc       = r_id_pc;
  assign id_instr    = r_id_instr;
  assign id_valid    = r_id_valid;
  assign stall_count = r_stall_count;
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= PC_RESET;
      r_old_addr    <= '0;
      r_skid        <= '0;
      r_skid_pc     <= '0;
      r_id_pc       <= '0;
      r_id_instr    <= '0;
      r_id_valid    <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (freeze && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end

      if (branch_taken) begin
        // Redirect wins over freeze and ack; IF/ID becomes a bubble.
        r_id_valid <= 1'b0;
        r_id_instr <= '0;
        r_pc       <= branch_addr;
        case (r_state)
          S_REQ: begin
            // An acked word is simply dropped; an unacked request must be
            // drained before the new target can be requested.
            if (!imem_ack) begin
              r_old_addr <= r_pc;
              r_state    <= S_DISCARD;
            end
          end
          S_HOLD:    r_state <= S_REQ;  // skid contents dropped
          S_DISCARD: r_state <= S_DISCARD;  // newest target replaces pc
          default:   r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (imem_ack) begin
              if (!freeze) begin
                r_id_instr <= imem_rdata;
                r_id_pc    <= w_pc_plus4;
                r_id_valid <= 1'b1;
                r_pc       <= w_pc_plus4;
              end else begin
                // ID cannot take the word yet: park it and stop requesting.
                r_skid    <= imem_rdata;
                r_skid_pc <= w_pc_plus4;
                r_state   <= S_HOLD;
              end
            end else if (!freeze) begin
              r_id_valid <= 1'b0;
            end
          end
          S_HOLD: begin
            if (!freeze) begin
              r_id_instr <= r_skid;
              r_id_pc    <= r_skid_pc;
              r_id_valid <= 1'b1;
              r_pc       <= w_pc_plus4;
              r_state    <= S_REQ;
            end
          end
          S_DISCARD: begin
            // Stale data is never delivered.
            if (imem_ack) begin
              r_state <= S_REQ;
            end
            if (!freeze) begin
              r_id_valid <= 1'b0;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_unit.sv
// ---------------------------------------------------------------------------
// Bench for fetch_stage_unit. A small memory responder with programmable
// latency feeds the DUT; a behavioural model built from a pending-word queue
// and a stale-request queue predicts every output after each clock.
// ---------------------------------------------------------------------------
module tb_fetch_stage_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [15:0] stall_count;
  logic [1:0]  dbg_state;

  fetch_stage_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .stall_count  (stall_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  logic        m_id_valid;
  int unsigned m_stall;
  logic [31:0] skid_q[$];  // fetched word waiting for ID (at most one)
  logic [31:0] disc_q[$];  // address of a request whose data must be thrown away

  // memory responder latency control
  int lat_left = -1;
  int lat_lo   = 0;
  int lat_hi   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic m_req();
    return (skid_q.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return (disc_q.size() != 0) ? disc_q[0] : m_pc;
  endfunction

  task automatic model_reset();
    m_pc       = 32'h0;
    m_id_pc    = 32'h0;
    m_id_instr = 32'h0;
    m_id_valid = 1'b0;
    m_stall    = 0;
    skid_q.delete();
    disc_q.delete();
    lat_left   = -1;
  endtask

  task automatic model_clock(input logic fr, input logic br, input logic [31:0] ba,
                             input logic ack, input logic [31:0] rd);
    if (fr && (m_stall < 32'd65535)) m_stall++;
    if (br) begin
      m_id_valid = 1'b0;
      m_id_instr = 32'h0;
      if (disc_q.size() != 0) begin
        // still draining the same stale request
      end else if (skid_q.size() != 0) begin
        skid_q.delete();
      end else if (!ack) begin
        disc_q.push_back(m_pc);
      end
      m_pc = ba;
    end else if (disc_q.size() != 0) begin
      if (ack) void'(disc_q.pop_front());
      if (!fr) m_id_valid = 1'b0;
    end else if (skid_q.size() != 0) begin
      if (!fr) begin
        m_id_instr = skid_q.pop_front();
        m_pc       = m_pc + 32'd4;
        m_id_pc    = m_pc;
        m_id_valid = 1'b1;
      end
    end else if (ack) begin
      if (!fr) begin
        m_id_instr = rd;
        m_pc       = m_pc + 32'd4;
        m_id_pc    = m_pc;
        m_id_valid = 1'b1;
      end else begin
        skid_q.push_back(rd);
      end
    end else if (!fr) begin
      m_id_valid = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("imem_req", 64'(imem_req), 64'(m_req()));
    if (m_req()) check("imem_addr", 64'(imem_addr), 64'(m_addr()));
    check("id_valid", 64'(id_valid), 64'(m_id_valid));
    check("id_pc", 64'(id_pc), 64'(m_id_pc));
    check("id_instr", 64'(id_instr), 64'(m_id_instr));
    check("stall_count", 64'(stall_count), 64'(m_stall));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  // One clock: memory responds to the request visible now, then the model
  // advances with exactly the inputs the DUT sampled.
  task automatic step(input logic fr, input logic br, input logic [31:0] ba);
    logic        ack;
    logic [31:0] rd;
    logic        req_now;
    logic [31:0] addr_now;
    req_now  = m_req();
    addr_now = m_addr();
    ack      = 1'b0;
    rd       = $urandom;  // junk unless acked
    if (req_now) begin
      if (lat_left < 0) lat_left = $urandom_range(lat_hi, lat_lo);
      if (lat_left == 0) begin
        ack = 1'b1;
        rd  = mem_word(addr_now);
      end
    end
    freeze       = fr;
    branch_taken = br;
    branch_addr  = ba;
    imem_ack     = ack;
    imem_rdata   = rd;
    @(posedge clk);
    if (ack) lat_left = -1;
    else if (req_now) lat_left--;
    model_clock(fr, br, ba, ack, rd);
    #1;
    compare_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset();
    check("rst_req", 64'(imem_req), 64'h1);
    check("rst_addr", 64'(imem_addr), 64'h0);
    check("rst_valid", 64'(id_valid), 64'h0);
    check("rst_stall", 64'(stall_count), 64'h0);

    // zero-wait memory, back-to-back fetch
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 4; i++) begin
      check("p1_addr", 64'(imem_addr), 64'(i * 4));
      step(1'b0, 1'b0, 32'h0);
      check("p1_id_pc", 64'(id_pc), 64'((i + 1) * 4));
      check("p1_valid", 64'(id_valid), 64'h1);
    end

    // three-cycle latency at 0x10
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 3; i++) begin
      check("p2_addr", 64'(imem_addr), 64'h10);
      step(1'b0, 1'b0, 32'h0);
      if (i < 2) check("p2_bubble", 64'(id_valid), 64'h0);
    end
    check("p2_valid", 64'(id_valid), 64'h1);
    check("p2_id_pc", 64'(id_pc), 64'h14);
    check("p2_instr", 64'(id_instr), 64'(mem_word(32'h10)));

    // freeze on ack at 0x20
    do_reset();
    lat_lo = 0; lat_hi = 0;
    step(1'b0, 1'b1, 32'h20);
    check("p3_addr", 64'(imem_addr), 64'h20);
    step(1'b1, 1'b0, 32'h0);
    check("p3_req_off", 64'(imem_req), 64'h0);
    step(1'b1, 1'b0, 32'h0);
    check("p3_req_off2", 64'(imem_req), 64'h0);
    check("p3_hold_valid", 64'(id_valid), 64'h0);
    check("p3_stall", 64'(stall_count), 64'h2);
    step(1'b0, 1'b0, 32'h0);
    check("p3_id_pc", 64'(id_pc), 64'h24);
    check("p3_instr", 64'(id_instr), 64'(mem_word(32'h20)));
    check("p3_next_addr", 64'(imem_addr), 64'h24);

    // branch while 0x40 is outstanding
    step(1'b0, 1'b1, 32'h40);
    lat_lo = 2; lat_hi = 2;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    check("p4_flush", 64'(id_valid), 64'h0);
    check("p4_old_addr", 64'(imem_addr), 64'h40);
    check("p4_req", 64'(imem_req), 64'h1);
    step(1'b0, 1'b0, 32'h0);
    check("p4_dropped", 64'(id_valid), 64'h0);
    check("p4_new_addr", 64'(imem_addr), 64'h100);
    lat_lo = 0; lat_hi = 0;
    step(1'b0, 1'b0, 32'h0);
    check("p4_id_pc", 64'(id_pc), 64'h104);

    // branch + freeze while holding a skid word
    step(1'b1, 1'b0, 32'h0);
    check("p5_hold", 64'(imem_req), 64'h0);
    step(1'b1, 1'b1, 32'h200);
    check("p5_valid", 64'(id_valid), 64'h0);
    check("p5_addr", 64'(imem_addr), 64'h200);
    step(1'b0, 1'b0, 32'h0);
    check("p5_id_pc", 64'(id_pc), 64'h204);

    // PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    check("p6_wrap_id_pc", 64'(id_pc), 64'h0);
    check("p6_wrap_addr", 64'(imem_addr), 64'h0);

    // randomized traffic with occasional reset
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(3, 0) == 0), ($urandom_range(19, 0) == 0), $urandom);
      end
    end

    // stall counter saturation
    do_reset();
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b0, 32'h0);
    check("p6_saturate", 64'(stall_count), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
